// File: rtl/dino_game_if.sv
// dino_game_if: bundle between the pixel/scan side and the game controller.
//   scan side (master) drives: h_cnt, v_cnt, valid, black_dino, black_cactus, jump_btn
//   controller (slave) drives: state, frame_tick, scroll_en, speed, score, hit
interface dino_game_if;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        valid;
  logic        black_dino;
  logic        black_cactus;
  logic        jump_btn;
  logic [1:0]  state;
  logic        frame_tick;
  logic        scroll_en;
  logic [3:0]  speed;
  logic [13:0] score;
  logic        hit;

  modport master (
    output h_cnt, v_cnt, valid, black_dino, black_cactus, jump_btn,
    input  state, frame_tick, scroll_en, speed, score, hit
  );

  modport slave (
    input  h_cnt, v_cnt, valid, black_dino, black_cactus, jump_btn,
    output state, frame_tick, scroll_en, speed, score, hit
  );
endinterface

// File: rtl/dino_game_ctrl.sv
// dino_game_ctrl: IDLE/RUN/OVER sequencer for the dino runner.
// Watches the scan counters and per-pixel shape hits, produces the frame tick,
// per-frame collision flag, scroll enable, scroll speed and saturating score.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : dino_game_if.slave (scan/shape inputs, game outputs); all outputs registered
module dino_game_ctrl #(
  parameter int unsigned SPEED_INIT   = 2,
  parameter int unsigned SPEED_MAX    = 8,
  parameter int unsigned SCORE_DIV    = 6,
  parameter int unsigned SPEED_UP_PTS = 100,
  parameter int unsigned OVER_HOLD    = 60
) (
  input  logic        clk,
  input  logic        rst,
  dino_game_if.slave  bus
);

  localparam int unsigned DIV_W     = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int unsigned PTS_W     = (SPEED_UP_PTS > 1) ? $clog2(SPEED_UP_PTS) : 1;
  localparam int unsigned HOLD_W    = (OVER_HOLD > 0) ? $clog2(OVER_HOLD + 1) : 1;
  localparam int unsigned SCORE_W   = 14;
  localparam int unsigned SPEED_W   = 4;
  localparam int unsigned SCORE_MAX = 9999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 cond_q, cond_d;
  logic                 tick_q, tick_d;
  logic                 scroll_q, scroll_d;
  logic                 hit_q, hit_d;
  logic [SPEED_W-1:0]   speed_q, speed_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [PTS_W-1:0]     pts_q, pts_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 cond_c;
  logic                 overlap_c;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cond_q   <= 1'b0;
      tick_q   <= 1'b0;
      scroll_q <= 1'b0;
      hit_q    <= 1'b0;
      speed_q  <= SPEED_W'(SPEED_INIT);
      score_q  <= '0;
      div_q    <= '0;
      pts_q    <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      cond_q   <= cond_d;
      tick_q   <= tick_d;
      scroll_q <= scroll_d;
      hit_q    <= hit_d;
      speed_q  <= speed_d;
      score_q  <= score_d;
      div_q    <= div_d;
      pts_q    <= pts_d;
      hold_q   <= hold_d;
    end
  end

  // Next-state, scoring and collision logic; tick_q is the tick being acted on
  always_comb begin
    state_d  = state_q;
    speed_d  = speed_q;
    score_d  = score_q;
    div_d    = div_q;
    pts_d    = pts_q;
    hold_d   = hold_q;
    hit_d    = 1'b0;

    cond_c    = (bus.v_cnt == 10'd480) && (bus.h_cnt == 10'd0);
    overlap_c = bus.valid && bus.black_dino && bus.black_cactus;
    cond_d    = cond_c;
    tick_d    = cond_c && !cond_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.jump_btn) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (tick_q && hit_q) begin
          state_d = ST_OVER;
        end else if (tick_q) begin
          if (div_q == DIV_W'(SCORE_DIV - 1)) begin
            div_d = '0;
            if (score_q < SCORE_W'(SCORE_MAX)) begin
              score_d = score_q + SCORE_W'(1);
              if (pts_q == PTS_W'(SPEED_UP_PTS - 1)) begin
                pts_d = '0;
                if (speed_q < SPEED_W'(SPEED_MAX)) speed_d = speed_q + SPEED_W'(1);
              end else begin
                pts_d = pts_q + PTS_W'(1);
              end
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end
      ST_OVER: begin
        // Restart check uses the pre-update hold count, so a press on the
        // hold-completing tick is still locked out.
        if (tick_q && (hold_q < HOLD_W'(OVER_HOLD))) hold_d = hold_q + HOLD_W'(1);
        if (bus.jump_btn && (hold_q >= HOLD_W'(OVER_HOLD))) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    // Fresh game on every entry to RUN
    if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
      score_d = '0;
      speed_d = SPEED_W'(SPEED_INIT);
      div_d   = '0;
      pts_d   = '0;
    end

    if ((state_d == ST_OVER) && (state_q != ST_OVER)) hold_d = '0;

    // Tick clears first, an overlap in the same cycle then sets for the next frame
    if ((state_d == ST_RUN) && (state_q == ST_RUN))
      hit_d = (tick_q ? 1'b0 : hit_q) | overlap_c;

    scroll_d = (state_d == ST_RUN);
  end

  assign bus.state      = state_q;
  assign bus.frame_tick = tick_q;
  assign bus.scroll_en  = scroll_q;
  assign bus.speed      = speed_q;
  assign bus.score      = score_q;
  assign bus.hit        = hit_q;

endmodule
